matrix_pingpong_buffer: RTL and testbench
=========================================

MATRIX_PINGPONG_BUFFER -- requirements
Module: matrix_pingpong_buffer

Interface
REQ-001 SHALL have parameter N, default 16, meaning signed width of each real/imag component (Q8 fixed point).
REQ-002 SHALL have parameter ELEMENTS, default 8, meaning complex entries per 4x2 matrix frame.
REQ-003 SHALL have parameter ADDR_W, default 3, meaning read-address width (log2 ELEMENTS).
REQ-004 SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning the asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, meaning upstream element valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the buffer accepts an element this cycle.
REQ-009 SHALL have ports in_data_r and in_data_i, input, N signed each, meaning the element's real and imaginary parts.
REQ-010 SHALL have port in_last, input, 1, meaning the element is the final one of its frame.
REQ-011 SHALL have port start_calc, output, 1, meaning a one-cycle pulse to the downstream trace stage.
REQ-012 SHALL have port done_calc, input, 1, meaning the downstream stage has finished.
REQ-013 SHALL have port rd_addr, input, ADDR_W, meaning the element index read by downstream.
REQ-014 SHALL have ports rd_data_r and rd_data_i, output, N signed each, meaning the element at rd_addr of the read bank.
REQ-015 SHALL have port frame_err, output, 1, meaning a one-cycle pulse on a framing violation.

Function
REQ-016 SHALL hold two banks (0,1), each with ELEMENTS complex entries, one full flag per bank, and pointers wr_bank and rd_bank.
REQ-017 SHALL drive in_ready = ~full[wr_bank] combinationally, with no combinational path from done_calc.
REQ-018 SHALL accept an element on a rising edge with in_valid & in_ready: write it to mem[wr_bank][wr_cnt], then wr_cnt++.
REQ-019 SHALL complete a frame on accepting an element at wr_cnt == ELEMENTS-1: set full[wr_bank], toggle wr_bank, clear wr_cnt.
REQ-020 SHALL, when in_last=1 is accepted with wr_cnt < ELEMENTS-1, discard the partial frame (wr_cnt<=0, no full set, wr_bank unchanged) and pulse frame_err.
REQ-021 SHALL, when the element at wr_cnt == ELEMENTS-1 is accepted with in_last=0, complete the frame per REQ-019 and also pulse frame_err.
REQ-022 SHALL implement a read FSM with states IDLE, START, WAIT.
REQ-023 SHALL transition IDLE->START when full[rd_bank]=1.
REQ-024 SHALL transition START->WAIT unconditionally; start_calc SHALL be 1 only in START (registered decode).
REQ-025 SHALL detect the rising edge of done_calc (done_calc & ~done_q); it is ignored outside WAIT.
REQ-026 SHALL, on a done_calc rise in WAIT, clear full[rd_bank], toggle rd_bank and return to IDLE.
REQ-027 SHALL give latency as follows: the last write at edge k sets full; start_calc is high from edge k+1 to edge k+2 (FSM idle, bank is rd_bank).
REQ-028 SHALL drive rd_data_r/i = mem[rd_bank][rd_addr] combinationally (zero read latency); contents are stable from START until release.
REQ-029 SHALL treat a release of bank X and a write into bank Y on the same edge as independent.
REQ-030 SHALL raise in_ready in the cycle after the edge that releases the bank selected by wr_bank.
REQ-031 SHALL keep data unmodified: no scaling, rounding or saturation.

Reset
REQ-032 SHALL, while rst=1, asynchronously set full=00, wr_bank=0, rd_bank=0, wr_cnt=0, FSM=IDLE, done_q=0, start_calc=0 and frame_err=0, with in_ready therefore 1.
REQ-033 SHALL discard a partial or unconsumed frame on reset asserted mid-operation; memory contents need not reset, and rd_data is undefined before the first write.

Verification
REQ-034 SHALL be verified for a single frame: 8 elements (k<<8)+j(k<<8), k=1..8, with in_last on the 8th -> start_calc pulses once, one cycle after the 8th write; rd_addr 0..7 returns 0x0100..0x0800.
REQ-035 SHALL be verified for back-to-back frames: frames A and B, no done_calc -> in_ready=0 after B completes; the done_calc rise switches rd_data to B, and start_calc fires for B two cycles after the rise.
REQ-036 SHALL be verified for early last: in_last on the 3rd element -> frame_err for one cycle, no start_calc; the next 8-element frame lands at bank 0 addresses 0..7.
REQ-037 SHALL be verified for missing last: 8 elements with in_last=0 -> frame_err pulses and start_calc still pulses.
REQ-038 SHALL be verified for level done: done_calc held high across release and the next START -> only one release per rising edge; the second frame is not released early.
REQ-039 SHALL be verified for reset mid-frame: rst asserted after 5 elements -> start_calc=0, in_ready=1, and the next full frame produces a normal start_calc.

Source files
------------

// File: rtl/matrix_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// matrix_pingpong_buffer
//   Two-bank ping-pong buffer for 4x2 complex matrix frames. The upstream side
//   fills one bank while the downstream trace stage reads the other. A small
//   read FSM announces each full bank with a one-cycle start_calc pulse and
//   releases that bank on the rising edge of done_calc.
//
// Handshake: an element transfers on a rising clk edge where
//   in_valid & in_ready; in_ready depends only on registered state.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : element handshake
//   in_data_r/in_data_i  : signed element components, stored unmodified
//   in_last              : marks the final element of a frame
//   start_calc           : one-cycle pulse, read bank ready for downstream
//   done_calc            : downstream finished (rising edge is used)
//   rd_addr              : element index into the read bank
//   rd_data_r/rd_data_i  : combinational read of the read bank
//   frame_err            : one-cycle pulse on a framing violation
//   dbg_state            : read FSM state (0 IDLE, 1 START, 2 WAIT)
// -----------------------------------------------------------------------------
module matrix_pingpong_buffer #(
  parameter int N        = 16,
  parameter int ELEMENTS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_data_r,
  input  logic signed [N-1:0] in_data_i,
  input  logic                in_last,
  output logic                start_calc,
  input  logic                done_calc,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic signed [N-1:0] rd_data_r,
  output logic signed [N-1:0] rd_data_i,
  output logic                frame_err,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ELEMENTS - 1);

  logic signed [N-1:0] r_mem_r [0:1][0:ELEMENTS-1];
  logic signed [N-1:0] r_mem_i [0:1][0:ELEMENTS-1];

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_done_q;
  logic              r_frame_err;
  state_t            r_state;

  state_t            w_state_nxt;
  logic [1:0]        w_full_nxt;
  logic              w_accept;
  logic              w_at_last;
  logic              w_frame_done;
  logic              w_discard;
  logic              w_err;
  logic              w_done_rise;
  logic              w_release;

  // in_ready comes from registered flags only, so done_calc never reaches it
  // combinationally; a released bank is seen one cycle after the release edge.
  assign in_ready     = ~r_full[r_wr_bank];
  assign w_accept     = in_valid & in_ready;
  assign w_at_last    = (r_wr_cnt == LAST_IDX);
  assign w_frame_done = w_accept & w_at_last;
  assign w_discard    = w_accept & in_last & ~w_at_last;
  // Early last drops the partial frame; a missing last still completes it.
  assign w_err        = w_discard | (w_frame_done & ~in_last);
  assign w_done_rise  = done_calc & ~r_done_q;
  assign w_release    = (r_state == S_WAIT) & w_done_rise;

  assign rd_data_r = r_mem_r[r_rd_bank][rd_addr];
  assign rd_data_i = r_mem_i[r_rd_bank][rd_addr];
  assign frame_err = r_frame_err;

  // Storage is not reset; contents are only meaningful once a frame lands.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_r[r_wr_bank][r_wr_cnt] <= in_data_r;
      r_mem_i[r_wr_bank][r_wr_cnt] <= in_data_i;
    end
  end

  // Write pointer and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_frame_done) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_cnt  <= '0;
      end else if (w_discard) begin
        r_wr_cnt  <= '0;
      end else if (w_accept) begin
        r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
      end
    end
  end

  // A write can only target a non-full bank and a release only a full one,
  // so the set and clear below never hit the same bank on one edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_frame_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)    w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_rd_bank <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_full   <= w_full_nxt;
      r_done_q <= done_calc;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Read FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_full[r_rd_bank]) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read FSM: outputs decoded from the state register
  always_comb begin
    start_calc = (r_state == S_START);
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_matrix_pingpong_buffer.sv
module tb_matrix_pingpong_buffer;

  localparam int N        = 16;
  localparam int ELEMENTS = 8;
  localparam int ADDR_W   = 3;
  localparam int W        = 2 * N;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data_r;
  logic signed [N-1:0] in_data_i;
  logic                in_last;
  logic                start_calc;
  logic                done_calc;
  logic [ADDR_W-1:0]   rd_addr;
  logic signed [N-1:0] rd_data_r;
  logic signed [N-1:0] rd_data_i;
  logic                frame_err;
  logic [1:0]          dbg_state;

  matrix_pingpong_buffer #(.N(N), .ELEMENTS(ELEMENTS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_r(in_data_r), .in_data_i(in_data_i), .in_last(in_last),
    .start_calc(start_calc), .done_calc(done_calc),
    .rd_addr(rd_addr), .rd_data_r(rd_data_r), .rd_data_i(rd_data_i),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_pulses = 0;
  int err_pulses = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic         last;
    logic [N-1:0] exp_r;
    logic [N-1:0] exp_i;
  } vec_t;
  vec_t vecs[ELEMENTS];

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (start_calc) start_pulses++;
      if (frame_err)  err_pulses++;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; done_calc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one element and hold it until it is accepted on a rising edge.
  task automatic send_elem(input logic [N-1:0] re, input logic [N-1:0] im, input logic last);
    int n = 0;
    in_data_r = re; in_data_i = im; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("in_ready timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit last_on_final, input bit push);
    logic [N-1:0] re, im;
    for (int i = 0; i < n; i++) begin
      re = N'($urandom_range(0, 65535));
      im = N'($urandom_range(0, 65535));
      send_elem(re, im, (i == n - 1) && last_on_final);
      if (push) exp_q.push_back({re, im});
    end
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    @(negedge clk);
    while (!start_calc && n < 30) begin
      @(negedge clk); n++;
    end
    check(name, {63'd0, start_calc}, 64'd1);
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (start_pulses < target && n < 30) begin
      @(negedge clk); n++;
    end
  endtask

  // Read the whole read bank and compare against the scoreboard.
  task automatic readback(input string name);
    logic [W-1:0] e;
    for (int a = 0; a < ELEMENTS; a++) begin
      rd_addr = ADDR_W'(a);
      #1;
      if (exp_q.size() == 0) begin
        check({name, " queue empty"}, 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check(name, {32'd0, rd_data_r, rd_data_i}, {32'd0, e});
      end
    end
  endtask

  task automatic release_bank();
    @(posedge clk); #1 done_calc = 1'b1;
    @(posedge clk); #1 done_calc = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int s0, e0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; done_calc = 1'b0;
    in_data_r = '0; in_data_i = '0; rd_addr = '0;

    for (int k = 1; k <= ELEMENTS; k++) begin
      vecs[k-1].re    = N'(k << 8);
      vecs[k-1].im    = N'(k << 8);
      vecs[k-1].last  = (k == ELEMENTS);
      vecs[k-1].exp_r = N'(k * 256);
      vecs[k-1].exp_i = N'(k * 256);
    end

    // Reset state
    #2;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset start_calc", {63'd0, start_calc}, 64'd0);
    check("reset frame_err", {63'd0, frame_err}, 64'd0);
    check("reset state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    @(posedge clk); #1 rst = 1'b0;

    // Single frame from the vector table, with exact start latency
    s0 = start_pulses; e0 = err_pulses;
    for (int i = 0; i < ELEMENTS; i++) send_elem(vecs[i].re, vecs[i].im, vecs[i].last);
    @(negedge clk);
    check("t1 no start at k", {63'd0, start_calc}, 64'd0);
    check("t1 in_ready other bank", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    check("t1 start at k+1", {63'd0, start_calc}, 64'd1);
    check("t1 state START", {62'd0, dbg_state}, {62'd0, ST_START});
    @(negedge clk);
    check("t1 start dropped", {63'd0, start_calc}, 64'd0);
    check("t1 state WAIT", {62'd0, dbg_state}, {62'd0, ST_WAIT});
    for (int i = 0; i < ELEMENTS; i++) begin
      rd_addr = ADDR_W'(i);
      #1;
      check("t1 rd_data", {32'd0, rd_data_r, rd_data_i}, {32'd0, vecs[i].exp_r, vecs[i].exp_i});
    end
    check("t1 one start", 64'(start_pulses - s0), 64'd1);
    check("t1 no frame_err", 64'(err_pulses - e0), 64'd0);
    release_bank();
    @(negedge clk); @(negedge clk);
    check("t1 back to IDLE", {62'd0, dbg_state}, {62'd0, ST_IDLE});

    // Back-to-back frames A and B without done_calc
    s0 = start_pulses;
    send_frame(ELEMENTS, 1'b1, 1'b1);
    send_frame(ELEMENTS, 1'b1, 1'b1);
    @(negedge clk);
    check("t2 in_ready low both full", {63'd0, in_ready}, 64'd0);
    wait_pulses(s0 + 1);
    check("t2 only A started", 64'(start_pulses - s0), 64'd1);
    readback("t2 frame A");
    release_bank();
    @(negedge clk);
    check("t2 no start at release+1", {63'd0, start_calc}, 64'd0);
    check("t2 in_ready after release", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    check("t2 B start", {63'd0, start_calc}, 64'd1);
    readback("t2 frame B");
    release_bank();

    // Early last after a fresh reset
    apply_reset();
    s0 = start_pulses; e0 = err_pulses;
    send_frame(3, 1'b1, 1'b0);
    @(negedge clk);
    check("t3 frame_err pulse", {63'd0, frame_err}, 64'd1);
    @(negedge clk);
    check("t3 frame_err one cycle", {63'd0, frame_err}, 64'd0);
    check("t3 in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(negedge clk);
    check("t3 no start for partial", 64'(start_pulses - s0), 64'd0);
    send_frame(ELEMENTS, 1'b1, 1'b1);
    wait_start("t3 next frame start");
    check("t3 single err", 64'(err_pulses - e0), 64'd1);
    readback("t3 frame bank0");
    release_bank();

    // Missing last
    e0 = err_pulses;
    send_frame(ELEMENTS, 1'b0, 1'b1);
    wait_start("t4 start despite missing last");
    check("t4 frame_err once", 64'(err_pulses - e0), 64'd1);
    readback("t4 frame");
    release_bank();

    // Level done_calc must release only one frame
    s0 = start_pulses;
    send_frame(ELEMENTS, 1'b1, 1'b1);
    send_frame(ELEMENTS, 1'b1, 1'b1);
    wait_pulses(s0 + 1);
    check("t5 C started", 64'(start_pulses - s0), 64'd1);
    readback("t5 frame C");
    @(posedge clk); #1 done_calc = 1'b1;
    repeat (6) @(posedge clk);
    #1 done_calc = 1'b0;
    repeat (3) @(negedge clk);
    check("t5 D started once", 64'(start_pulses - s0), 64'd2);
    check("t5 D still held", {62'd0, dbg_state}, {62'd0, ST_WAIT});
    readback("t5 frame D");
    release_bank();

    // Reset in the middle of a frame
    send_frame(5, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("t6 async start_calc", {63'd0, start_calc}, 64'd0);
    check("t6 async in_ready", {63'd0, in_ready}, 64'd1);
    check("t6 async state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s0 = start_pulses;
    send_frame(ELEMENTS, 1'b1, 1'b1);
    wait_start("t6 start after reset");
    readback("t6 frame");
    release_bank();
    check("t6 single start", 64'(start_pulses - s0), 64'd1);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
